fpnew_opgroup_result_arbiter: RTL

//  Consumes the outputs of NumOpGroups opgroup blocks (ADDMUL, DIVSQRT, NONCOMP, CONV, ...).

---
 rtl/fpnew_opgroup_result_arbiter_if.sv | 27 ++
 rtl/fpnew_opgroup_result_arbiter.sv | 74 +++++++
 2 files changed

// File: rtl/fpnew_opgroup_result_arbiter_if.sv
// fpnew_opgroup_result_arbiter_if: opgroup input bundle and registered result stream of the result arbiter
interface fpnew_opgroup_result_arbiter_if #(
  parameter int NumOpGroups = 4,
  parameter int Width = 32,
  parameter type TagType = logic
);
  logic [NumOpGroups-1:0][Width-1:0] inp_result_i;
  logic [NumOpGroups-1:0][4:0] inp_status_i;
  logic [NumOpGroups-1:0] inp_ext_bit_i;
  TagType inp_tag_i [NumOpGroups];
  logic [NumOpGroups-1:0] inp_valid_i;
  logic [NumOpGroups-1:0] inp_ready_o;
  logic [Width-1:0] result_o;
  logic [4:0] status_o;
  logic extension_bit_o;
  TagType tag_o;
  logic out_valid_o;
  logic out_ready_i;
  modport master (
    output inp_result_i, inp_status_i, inp_ext_bit_i, inp_tag_i, inp_valid_i, out_ready_i,
    input inp_ready_o, result_o, status_o, extension_bit_o, tag_o, out_valid_o
  );
  modport slave (
    input inp_result_i, inp_status_i, inp_ext_bit_i, inp_tag_i, inp_valid_i, out_ready_i,
    output inp_ready_o, result_o, status_o, extension_bit_o, tag_o, out_valid_o
  );
endinterface

// File: rtl/fpnew_opgroup_result_arbiter.sv
// fpnew_opgroup_result_arbiter: round-robin opgroup result arbiter into one registered slot; sticky fflags when FPNEW_RESULT_STICKY_FLAGS_EN is defined
module fpnew_opgroup_result_arbiter #(
  parameter int NumOpGroups = 4,
  parameter int Width = 32,
  parameter type TagType = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic fflags_clr_i,
  output logic [4:0] fflags_o,
  output logic busy_o,
  fpnew_opgroup_result_arbiter_if.slave bus
);
  localparam int PtrW = $clog2(NumOpGroups);
  logic [PtrW-1:0] ptr_q, ptr_d, gnt, idx;
  logic found, free, xfer, out_valid_q, ext_q;
  logic [Width-1:0] result_q;
  logic [4:0] status_q;
  TagType tag_q;
  assign free = !out_valid_q | bus.out_ready_i;
  always_comb begin
    found = 1'b0;
    gnt = ptr_q;
    idx = '0;
    for (int i = NumOpGroups - 1; i >= 0; i--) begin
      idx = PtrW'((int'(ptr_q) + i) % NumOpGroups);
      if (bus.inp_valid_i[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  assign xfer = found & free & !flush_i;
  assign ptr_d = (int'(gnt) == NumOpGroups - 1) ? '0 : gnt + 1'b1;
  assign bus.inp_ready_o = xfer ? NumOpGroups'(1) << gnt : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      result_q <= '0;
      status_q <= '0;
      ext_q <= 1'b0;
      tag_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= flush_i ? 1'b0 : free ? xfer : out_valid_q;
      if (xfer) begin
        result_q <= bus.inp_result_i[gnt];
        status_q <= bus.inp_status_i[gnt];
        ext_q <= bus.inp_ext_bit_i[gnt];
        tag_q <= bus.inp_tag_i[gnt];
        ptr_q <= ptr_d;
      end
    end
  end
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o = result_q;
  assign bus.status_o = status_q;
  assign bus.extension_bit_o = ext_q;
  assign bus.tag_o = tag_q;
  assign busy_o = out_valid_q | (|bus.inp_valid_i);
`ifdef FPNEW_RESULT_STICKY_FLAGS_EN
  logic [4:0] fflags_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fflags_q <= '0;
    else fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q) | (out_valid_q & bus.out_ready_i ? status_q : 5'b0);
  end
  assign fflags_o = fflags_q;
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = fflags_clr_i;
  assign fflags_o = '0;
`endif
endmodule
